rotating_square_n: RTL and testbench

Parametrised successor to the 4-digit rotating-square animator. It drives a "square" that circulates around the outer edge of a row of `DIGITS` seven-segment digits, with run/pause, runtime direction and a 4-step speed select. Per-digit segment patterns come out on a flat bus that feeds the existing multiplexed display driver. A `tick` strobe and the position register are exported for debug and verification.

---
 rtl/rotating_square_n.sv | 65 ++++++
 tb/tb_rotating_square_n.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rotating_square_n.sv
// Rotating-square animator for a row of DIGITS seven-segment digits.
// A free-running prescaler produces a step strobe that walks a square around the display edge.
module rotating_square_n #(
    parameter int DIGITS       = 4,
    parameter int base_counter = 26
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          cw,
    input  logic [1:0]                    speed,
    output logic [8*DIGITS-1:0]           sseg,
    output logic [$clog2(2*DIGITS)-1:0]   pos,
    output logic                          tick
);

    localparam int PW = $clog2(2*DIGITS);
    localparam logic [PW-1:0] POS_LAST = PW'(2*DIGITS-1);
    localparam logic [base_counter-1:0] ALL_ONES = '1;

    localparam logic [7:0] SEG_UPPER = 8'h9C;
    localparam logic [7:0] SEG_LOWER = 8'hA3;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    logic [base_counter-1:0] prescale;
    logic [base_counter-1:0] mask;

    // Only the low (base_counter - speed) bits take part in the terminal-count match,
    // so changing speed does not disturb the prescaler itself.
    assign mask = ALL_ONES >> speed;
    assign tick = en & ((prescale & mask) == mask);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale <= '0;
        end else if (en) begin
            prescale <= prescale + base_counter'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos <= '0;
        end else if (tick) begin
            if (cw) begin
                pos <= (pos == POS_LAST) ? '0 : pos + PW'(1);
            end else begin
                pos <= (pos == '0) ? POS_LAST : pos - PW'(1);
            end
        end
    end

    // Top row walks left to right, bottom row walks right to left.
    always_comb begin
        sseg = {DIGITS{SEG_BLANK}};
        for (int k = 0; k < DIGITS; k++) begin
            if (pos == PW'(DIGITS - 1 - k)) begin
                sseg[8*k +: 8] = SEG_UPPER;
            end else if (pos == PW'(DIGITS + k)) begin
                sseg[8*k +: 8] = SEG_LOWER;
            end
        end
    end

endmodule

// File: tb/tb_rotating_square_n.sv
// Bench for rotating_square_n: 4-digit and 6-digit instances driven together,
// checked every cycle against an arithmetic position/period model.
module tb_rotating_square_n;

    localparam int B = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        cw;
    logic [1:0]  speed;

    logic [31:0] sseg4;
    logic [2:0]  pos4;
    logic        tick4;
    logic [47:0] sseg6;
    logic [3:0]  pos6;
    logic        tick6;

    always #10 clk = ~clk;

    rotating_square_n #(.DIGITS(4), .base_counter(B)) dut4 (
        .clk(clk), .reset(reset), .en(en), .cw(cw), .speed(speed),
        .sseg(sseg4), .pos(pos4), .tick(tick4)
    );

    rotating_square_n #(.DIGITS(6), .base_counter(B)) dut6 (
        .clk(clk), .reset(reset), .en(en), .cw(cw), .speed(speed),
        .sseg(sseg6), .pos(pos6), .tick(tick6)
    );

    int n_vec  = 0;
    int n_miss = 0;

    int m_cnt  = 0;
    int m_pos4 = 0;
    int m_pos6 = 0;

    function automatic logic m_tick();
        int period;
        period = 1 << (B - int'(speed));
        return en && ((m_cnt % period) == period - 1);
    endfunction

    function automatic logic [63:0] exp_sseg(int d, int p);
        logic [63:0] r;
        logic [7:0]  b;
        r = '0;
        for (int k = 0; k < d; k++) begin
            b = 8'hFF;
            if (p < d && k == d - 1 - p) b = 8'h9C;
            if (p >= d && k == p - d)    b = 8'hA3;
            r = r | (64'(b) << (8 * k));
        end
        return r;
    endfunction

    function automatic int nonblank6(logic [47:0] s);
        int c;
        c = 0;
        for (int k = 0; k < 6; k++) if (s[8*k +: 8] != 8'hFF) c++;
        return c;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: count clocks while enabled, step modulo 2*DIGITS on each period end.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt  = 0;
            m_pos4 = 0;
            m_pos6 = 0;
        end else if (en) begin
            if (m_tick()) begin
                m_pos4 = cw ? (m_pos4 + 1) % 8  : (m_pos4 + 7) % 8;
                m_pos6 = cw ? (m_pos6 + 1) % 12 : (m_pos6 + 11) % 12;
            end
            m_cnt = (m_cnt + 1) % (1 << B);
        end
    end

    always @(negedge clk) begin
        check("tick4", 64'(tick4), 64'(m_tick()));
        check("tick6", 64'(tick6), 64'(m_tick()));
        check("pos4", 64'(pos4), 64'(m_pos4));
        check("pos6", 64'(pos6), 64'(m_pos6));
        check("sseg4", 64'(sseg4), exp_sseg(4, m_pos4));
        check("sseg6", 64'(sseg6), exp_sseg(6, m_pos6));
        check("nonblank6", 64'(nonblank6(sseg6)), 64'd1);
        if (m_pos4 == 3) check("sseg4_pos3", 64'(sseg4), 64'hFFFF_FF9C);
        if (m_pos4 == 4) check("sseg4_pos4", 64'(sseg4), 64'hFFFF_FFA3);
        if (m_pos4 == 7) check("sseg4_pos7", 64'(sseg4), 64'hA3FF_FFFF);
        if (m_pos6 == 11) check("sseg6_pos11", 64'(sseg6[47:40]), 64'hA3);
    end

    task automatic wait_step(input int limit, output int n);
        logic [2:0] p0;
        p0 = pos4;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (pos4 == p0 && n < limit);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3 reset = 1'b1;
        #1;
        check("rst_sseg4", 64'(sseg4), 64'h9CFF_FFFF);
        check("rst_pos4", 64'(pos4), 64'd0);
        check("rst_tick4", 64'(tick4), 64'd0);
        check("rst_sseg6", 64'(sseg6[47:40]), 64'h9C);
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int n;
        int p;
        reset = 1'b1;
        en    = 1'b1;
        cw    = 1'b1;
        speed = 2'd0;
        repeat (2) @(negedge clk);

        // Clockwise sweep: first step on the 32nd edge, then every 32
        release_reset();
        wait_step(100, n);
        check("first_step_edges", 64'(n), 64'd32);
        check("first_step_pos", 64'(pos4), 64'd1);
        wait_step(100, n);
        check("cw_period", 64'(n), 64'd32);
        repeat (300) @(negedge clk);

        // Counter-clockwise wrap from reset
        do_reset();
        cw = 1'b0;
        release_reset();
        wait_step(100, n);
        check("ccw_first_pos", 64'(pos4), 64'd7);
        check("ccw_first_sseg", 64'(sseg4), 64'hA3FF_FFFF);
        wait_step(100, n);
        check("ccw_second_pos", 64'(pos4), 64'd6);

        // Pause 100 clocks, 10 clocks into a period: 22 clocks remain afterwards
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1 en = 1'b0;
        p = int'(pos4);
        repeat (100) @(negedge clk);
        check("pause_pos", 64'(pos4), 64'(p));
        #1 en = 1'b1;
        wait_step(100, n);
        check("resume_edges", 64'(n), 64'd22);

        // Speed 2: 8-clock period from a fresh prescaler
        do_reset();
        cw    = 1'b1;
        speed = 2'd2;
        release_reset();
        wait_step(100, n);
        check("spd2_first", 64'(n), 64'd8);
        wait_step(100, n);
        check("spd2_period", 64'(n), 64'd8);

        // Direction toggle between ticks reverses at the next tick
        p = int'(pos4);
        @(negedge clk);
        #1 cw = 1'b0;
        wait_step(100, n);
        check("toggle_pos", 64'(pos4), 64'((p + 7) % 8));
        check("toggle_edges", 64'(n), 64'd8);

        // Randomized run
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 15) == 0) en = ~en;
            if ($urandom_range(0, 3) != 0) en = 1'b1;
            if ($urandom_range(0, 40) == 0) cw = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 60) == 0) speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1500) == 0) begin
                reset = 1'b1;
                #2 reset = 1'b0;
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
